// File: rtl/i2c_master_tx_burst.sv
`default_nettype none
// ============================================================================
// i2c_master_tx_burst : I2C master write engine (START, addr+W, byte burst, STOP)
// Optional: define I2C_CLK_STRETCH_EN to honour slave clock stretching.
// Revision: 1.0
// ============================================================================
module i2c_master_tx_burst #(
  parameter int CLK_DIV = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [6:0]       addr,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  input  logic             tx_last,
  output logic             tx_ready,
  output logic             scl_oe,
  output logic             sda_oe,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             busy,
  output logic             done,
  output logic             nack,
  output logic [CNT_W-1:0] byte_cnt
);
  localparam int            QW   = $clog2(CLK_DIV);
  localparam logic [QW-1:0] QMAX = QW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_LOAD, S_DATA, S_DATA_ACK, S_STOP
  } state_t;

  state_t        state;
  logic [QW-1:0] qcnt;
  logic [1:0]    phase;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          last_byte;
  logic          ack_smp;
  logic          stall;

`ifdef I2C_CLK_STRETCH_EN
  // While SCL is released, a slave holding it low freezes the quarter timer.
  assign stall = (state inside {S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK}) &&
                 phase[1] && !scl_in;
`else
  logic unused_scl_in;
  assign unused_scl_in = scl_in;
  assign stall         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      qcnt      <= '0;
      phase     <= 2'd0;
      bit_idx   <= 3'd0;
      shreg     <= 8'd0;
      last_byte <= 1'b0;
      ack_smp   <= 1'b0;
      scl_oe    <= 1'b0;
      sda_oe    <= 1'b0;
      tx_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      nack      <= 1'b0;
      byte_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            shreg    <= {addr, 1'b0};
            nack     <= 1'b0;
            byte_cnt <= '0;
            busy     <= 1'b1;
            qcnt     <= '0;
            phase    <= 2'd0;
            bit_idx  <= 3'd0;
            state    <= S_START;
          end
        end
        S_LOAD: begin
          if (tx_valid) begin
            shreg     <= tx_data;
            last_byte <= tx_last;
            tx_ready  <= 1'b0;
            qcnt      <= '0;
            phase     <= 2'd0;
            bit_idx   <= 3'd0;
            sda_oe    <= ~tx_data[7];
            state     <= S_DATA;
          end
        end
        default: begin
          if (!stall) begin
            if (qcnt != QMAX) begin
              qcnt <= qcnt + 1'b1;
            end else begin
              qcnt <= '0;
              if (phase == 2'd2) ack_smp <= sda_in;
              if (phase != 2'd3) begin
                phase <= phase + 2'd1;
                case (state)
                  S_START: if (phase == 2'd1) sda_oe <= 1'b1;
                  S_STOP: begin
                    if (phase == 2'd0)      scl_oe <= 1'b0;
                    else if (phase == 2'd1) sda_oe <= 1'b0;
                  end
                  default: if (phase == 2'd1) scl_oe <= 1'b0;
                endcase
              end else begin
                // Bit/state boundary: every new bit or state opens at q0 with SCL low.
                phase <= 2'd0;
                case (state)
                  S_START: begin
                    scl_oe <= 1'b1;
                    sda_oe <= ~shreg[7];
                    state  <= S_ADDR;
                  end
                  S_ADDR, S_DATA: begin
                    scl_oe <= 1'b1;
                    if (bit_idx == 3'd7) begin
                      sda_oe <= 1'b0;
                      state  <= (state == S_ADDR) ? S_ADDR_ACK : S_DATA_ACK;
                    end else begin
                      bit_idx <= bit_idx + 3'd1;
                      shreg   <= {shreg[6:0], 1'b0};
                      sda_oe  <= ~shreg[6];
                    end
                  end
                  S_ADDR_ACK: begin
                    scl_oe <= 1'b1;
                    sda_oe <= 1'b1;
                    if (ack_smp) begin
                      nack  <= 1'b1;
                      state <= S_STOP;
                    end else begin
                      tx_ready <= 1'b1;
                      state    <= S_LOAD;
                    end
                  end
                  S_DATA_ACK: begin
                    scl_oe <= 1'b1;
                    sda_oe <= 1'b1;
                    if (ack_smp) begin
                      nack  <= 1'b1;
                      state <= S_STOP;
                    end else begin
                      if (byte_cnt != {CNT_W{1'b1}}) byte_cnt <= byte_cnt + 1'b1;
                      if (last_byte) begin
                        state <= S_STOP;
                      end else begin
                        tx_ready <= 1'b1;
                        state    <= S_LOAD;
                      end
                    end
                  end
                  S_STOP: begin
                    scl_oe <= 1'b0;
                    sda_oe <= 1'b0;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= S_IDLE;
                  end
                  default: ;
                endcase
              end
            end
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_master_tx_burst.sv
`default_nettype none
// ============================================================================
// tb_i2c_master_tx_burst : directed bench with a bus monitor and ACKing slave.
// Revision: 1.0
// ============================================================================
module tb_i2c_master_tx_burst;
  localparam int CLK_DIV = 4;
  localparam int CNT_W   = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [6:0]       addr = 7'd0;
  logic [7:0]       tx_data = 8'd0;
  logic             tx_valid = 1'b0;
  logic             tx_last = 1'b0;
  logic             tx_ready, scl_oe, sda_oe, busy, done, nack;
  logic [CNT_W-1:0] byte_cnt;
  logic             scl_in, sda_in;
  logic             slave_pull = 1'b0;
  logic             stretch = 1'b0;

  assign scl_in = !scl_oe && !stretch;
  assign sda_in = !sda_oe && !slave_pull;

  i2c_master_tx_burst #(.CLK_DIV(CLK_DIV), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .addr(addr),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .scl_in(scl_in), .sda_in(sda_in),
    .busy(busy), .done(done), .nack(nack), .byte_cnt(byte_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor and slave: decodes START/STOP/bytes, ACKs every byte except nack_byte.
  int         start_cnt = 0, stop_cnt = 0, done_cnt = 0, busy_cyc = 0, ready_cnt = 0;
  int         max_low = 0, low_run = 0, bitn = 0, byten = 0;
  int         nack_byte = -1;
  bit         in_ack = 1'b0;
  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  logic [7:0] shift = 8'd0;
  logic [7:0] cap[$];
  int         falls[$];

  always @(negedge clk) begin
    logic s_scl, s_sda;
    s_scl = scl_in;
    s_sda = sda_in;
    if (done)     done_cnt++;
    if (busy)     busy_cyc++;
    if (tx_ready) ready_cnt++;
    if (scl_oe) begin
      low_run++;
      if (low_run > max_low) max_low = low_run;
    end else begin
      low_run = 0;
    end
    if (prev_scl && s_scl && prev_sda && !s_sda) begin
      start_cnt++;
      bitn = 0; byten = 0; in_ack = 1'b0; slave_pull = 1'b0; max_low = 0;
      cap.delete();
      falls.delete();
    end else if (prev_scl && s_scl && !prev_sda && s_sda) begin
      stop_cnt++;
      bitn = 0; in_ack = 1'b0;
    end else if (!prev_scl && s_scl) begin
      if (!in_ack && bitn < 8) begin
        shift = {shift[6:0], s_sda};
        bitn++;
        if (bitn == 8) cap.push_back(shift);
      end
    end else if (prev_scl && !s_scl) begin
      falls.push_back(cyc);
      if (in_ack) begin
        in_ack = 1'b0; slave_pull = 1'b0; bitn = 0; byten++;
      end else if (bitn == 8) begin
        in_ack = 1'b1;
        slave_pull = (byten != nack_byte);
      end
    end
    prev_scl = s_scl;
    prev_sda = s_sda;
  end

  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  int s_done, s_stop, s_busy, s_ready, s_start;
  task automatic snap();
    s_done = done_cnt; s_stop = stop_cnt; s_busy = busy_cyc;
    s_ready = ready_cnt; s_start = start_cnt;
  endtask

  task automatic issue_start(input logic [6:0] a);
    addr  = a;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offers one byte once tx_ready is up; ok=0 if the transfer ends first.
  task automatic present(input logic [7:0] d, input logic l, input int pre_delay, output bit ok);
    int n = 0;
    while (!tx_ready && busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    ok = tx_ready;
    if (ok) begin
      repeat (pre_delay) @(negedge clk);
      tx_valid = 1'b1; tx_data = d; tx_last = l;
      @(negedge clk);
      tx_valid = 1'b0; tx_last = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check(tag, busy, 0);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok, ok2;
    int k;
    repeat (3) @(negedge clk);
    check("rst_scl_oe", scl_oe, 0);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_nack", nack, 0);
    check("rst_byte_cnt", byte_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-byte write, all ACKed
    nack_byte = -1;
    snap();
    issue_start(7'h50);
    check("t1_busy", busy, 1);
    k = 1;
    while (!scl_oe && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("t1_latency", k - 1, 4 * CLK_DIV);
    present(8'hA5, 1'b1, 0, ok);
    check("t1_accept", ok, 1);
    wait_idle("t1_idle");
    check("t1_nbytes", cap.size(), 2);
    check("t1_addr_byte", cap[0], 8'hA0);
    check("t1_data_byte", cap[1], 8'hA5);
    check("t1_scl_period_addr", falls[1] - falls[0], 16);
    check("t1_scl_period_data", falls[13] - falls[12], 16);
    check("t1_nack", nack, 0);
    check("t1_byte_cnt", byte_cnt, 1);
    check("t1_done_pulses", done_cnt - s_done, 1);
    check("t1_stops", stop_cnt - s_stop, 1);
    check("t1_busy_cycles", busy_cyc - s_busy, 321);

    // Three-byte burst, source stalls 20 clk before byte 2
    snap();
    issue_start(7'h2A);
    present(8'h11, 1'b0, 0, ok);
    present(8'h22, 1'b0, 20, ok);
    present(8'h33, 1'b1, 0, ok);
    wait_idle("t2_idle");
    check("t2_nbytes", cap.size(), 4);
    check("t2_addr_byte", cap[0], 8'h54);
    check("t2_byte2", cap[2], 8'h22);
    check("t2_byte3", cap[3], 8'h33);
    check("t2_byte_cnt", byte_cnt, 3);
    check("t2_stops", stop_cnt - s_stop, 1);
    check("t2_scl_low_in_load", max_low, 29);
    check("t2_nack", nack, 0);

    // Address NACK
    nack_byte = 0;
    snap();
    issue_start(7'h3C);
    present(8'hFF, 1'b1, 0, ok);
    wait_idle("t3_idle");
    check("t3_accept", ok, 0);
    check("t3_ready_cycles", ready_cnt - s_ready, 0);
    check("t3_nack", nack, 1);
    check("t3_byte_cnt", byte_cnt, 0);
    check("t3_addr_byte", cap[0], 8'h78);
    check("t3_busy_cycles", busy_cyc - s_busy, 176);
    check("t3_stops", stop_cnt - s_stop, 1);

    // NACK on first data byte of a two-byte burst
    nack_byte = 1;
    snap();
    issue_start(7'h19);
    present(8'h5A, 1'b0, 0, ok);
    present(8'hC3, 1'b1, 0, ok2);
    wait_idle("t4_idle");
    check("t4_accept1", ok, 1);
    check("t4_accept2", ok2, 0);
    check("t4_nack", nack, 1);
    check("t4_byte_cnt", byte_cnt, 0);
    check("t4_data_byte", cap[1], 8'h5A);
    check("t4_stops", stop_cnt - s_stop, 1);

    // Reset mid-DATA, then a clean transfer with an ignored start while busy
    nack_byte = -1;
    issue_start(7'h33);
    present(8'h81, 1'b1, 0, ok);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_rst_scl_oe", scl_oe, 0);
    check("t5_rst_sda_oe", sda_oe, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_tx_ready", tx_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    snap();
    issue_start(7'h11);
    repeat (5) @(negedge clk);
    issue_start(7'h22);
    present(8'h7E, 1'b1, 0, ok);
    wait_idle("t5_idle");
    check("t5_addr_byte", cap[0], 8'h22);
    check("t5_data_byte", cap[1], 8'h7E);
    check("t5_starts", start_cnt - s_start, 1);
    check("t5_done_pulses", done_cnt - s_done, 1);
    check("t5_byte_cnt", byte_cnt, 1);
    check("t5_nack", nack, 0);

`ifdef I2C_CLK_STRETCH_EN
    // Slave stretches SCL 10 clk in q2 of data bit 3
    nack_byte = -1;
    snap();
    issue_start(7'h50);
    present(8'h96, 1'b1, 0, ok);
    repeat (55) @(negedge clk);
    stretch = 1'b1;
    repeat (10) @(negedge clk);
    stretch = 1'b0;
    wait_idle("t6_idle");
    check("t6_busy_cycles", busy_cyc - s_busy, 331);
    check("t6_bit3_period", falls[13] - falls[12], 26);
    check("t6_data_byte", cap[1], 8'h96);
    check("t6_nack", nack, 0);
    check("t6_byte_cnt", byte_cnt, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
